// File: rtl/i2c_config_target.sv
// I2C target exposing a small bank of 8-bit configuration registers.
// Pointer-addressed writes with auto-increment and sequential reads.
module i2c_config_target #(
  parameter logic [6:0]            DEV_ADDR  = 7'h52,
  parameter int unsigned           NUM_REGS  = 4,
  parameter logic [8*NUM_REGS-1:0] RESET_VAL = (8*NUM_REGS)'(32'h0000_00C1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    scl_in,
  input  logic                    sda_in,
  output logic                    sda_oe,
  output logic [8*NUM_REGS-1:0]   reg_q,
  output logic                    wr_strobe,
  output logic [3:0]              wr_index,
  output logic                    busy
);

  localparam int unsigned PTR_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t state, state_d;

  logic [1:0]               scl_sync, sda_sync;
  logic                     scl_h, sda_h;
  logic                     scl_s, sda_s;
  logic                     scl_rise, scl_fall, start_det, stop_det;

  logic [CNT_W-1:0]         cnt, cnt_d;
  logic [PTR_W-1:0]         ptr, ptr_d, ptr_inc;
  logic [7:0]               rx, rx_d, rx_shift;
  logic [6:0]               tx, tx_d;
  logic                     sda_oe_d, strobe_d, busy_d, we;
  logic [3:0]               index_d;
  logic                     byte_done, ptr_valid;
  logic [7:0]               rd_byte;
  logic [NUM_REGS-1:0][7:0] regs;

  // Pad synchronizers plus one history stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_h    <= scl_sync[1];
      sda_h    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

  assign byte_done = (cnt == CNT_W'(8));
  assign rx_shift  = {rx[6:0], sda_s};
  assign ptr_valid = (32'(ptr) < NUM_REGS);
  assign ptr_inc   = (ptr == PTR_W'(NUM_REGS - 1)) ? PTR_W'(0) : ptr + PTR_W'(1);
  assign reg_q     = regs;

  // Out-of-range pointers read back as all ones
  always_comb begin
    rd_byte = 8'hFF;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (ptr == PTR_W'(i)) rd_byte = regs[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    ptr_d    = ptr;
    rx_d     = rx;
    tx_d     = tx;
    sda_oe_d = sda_oe;
    strobe_d = 1'b0;
    index_d  = wr_index;
    busy_d   = busy;
    we       = 1'b0;

    if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && !byte_done) begin
            rx_d  = rx_shift;
            cnt_d = cnt + CNT_W'(1);
          end else if (scl_fall && byte_done) begin
            cnt_d = '0;
            if (rx[7:1] == DEV_ADDR) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rx[0]) begin
              state_d  = RDATA;
              tx_d     = rd_byte[6:0];
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        PTR: begin
          if (scl_rise && !byte_done) begin
            rx_d  = rx_shift;
            cnt_d = cnt + CNT_W'(1);
          end else if (scl_fall && byte_done) begin
            cnt_d    = '0;
            ptr_d    = rx[3:0];
            state_d  = PTR_ACK;
            sda_oe_d = 1'b1;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_d  = WDATA;
            sda_oe_d = 1'b0;
          end
        end
        WDATA: begin
          if (scl_rise && !byte_done) begin
            rx_d  = rx_shift;
            cnt_d = cnt + CNT_W'(1);
          end else if (scl_fall && byte_done) begin
            cnt_d    = '0;
            ptr_d    = ptr_inc;
            state_d  = WDATA_ACK;
            sda_oe_d = 1'b1;
            // Writes to a nonexistent register are acknowledged but dropped
            if (ptr_valid) begin
              we       = 1'b1;
              strobe_d = 1'b1;
              index_d  = ptr;
            end
          end
        end
        RDATA: begin
          if (scl_rise && !byte_done) begin
            cnt_d = cnt + CNT_W'(1);
          end else if (scl_fall) begin
            if (byte_done) begin
              cnt_d    = '0;
              ptr_d    = ptr_inc;
              state_d  = RDATA_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~tx[6];
              tx_d     = {tx[5:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          // Master NACK ends the read; ACK preloads the next byte
          if (scl_rise && sda_s) begin
            state_d = IGNORE;
          end else if (scl_fall) begin
            state_d  = RDATA;
            tx_d     = rd_byte[6:0];
            sda_oe_d = ~rd_byte[7];
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      ptr       <= '0;
      rx        <= '0;
      tx        <= '0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      busy      <= 1'b0;
      regs      <= RESET_VAL;
    end else begin
      cnt       <= cnt_d;
      ptr       <= ptr_d;
      rx        <= rx_d;
      tx        <= tx_d;
      sda_oe    <= sda_oe_d;
      wr_strobe <= strobe_d;
      wr_index  <= index_d;
      busy      <= busy_d;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (we && ptr == PTR_W'(i)) regs[i] <= rx;
      end
    end
  end

endmodule

// File: tb/tb_i2c_config_target.sv
// Directed bench for i2c_config_target: bus master model on a wired-AND SDA line.
module tb_i2c_config_target;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scl_m;
  logic        sda_m;
  logic        sda_line;
  logic        sda_oe;
  logic [31:0] reg_q;
  logic        wr_strobe;
  logic [3:0]  wr_index;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int strobes = 0;
  int oe_cnt = 0;
  logic [3:0] idx_log [8];

  assign sda_line = sda_m & ~sda_oe;

  i2c_config_target dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      idx_log[3'(strobes)] = wr_index;
      strobes = strobes + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (8) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  // One SCL period; samples the bus and the target's drive while SCL is high
  task automatic send_bit(input logic b, output logic line, output logic oe);
    sda_m = b; wq();
    scl_m = 1'b1; wq();
    line = sda_line;
    oe   = sda_oe;
    wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic l, o;
    for (int i = 7; i >= 0; i--) send_bit(b[i], l, o);
    send_bit(1'b1, l, o);
    ack = ~l;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d, output logic oe_mack);
    logic l, o;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, l, o);
      d[i] = l;
    end
    send_bit(nack, l, o);
    oe_mack = o;
    sda_m = 1'b1;
  endtask

  initial begin
    logic       ack, l, o;
    logic [7:0] d;
    int         s0, o0;

    reset_n = 1'b0;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_reg_q",  reg_q,             32'h0000_00C1);
    chk("rst_sda_oe", 32'(sda_oe),       32'h0);
    chk("rst_busy",   32'(busy),         32'h0);
    chk("rst_strobe", 32'(wr_strobe),    32'h0);
    chk("rst_index",  32'(wr_index),     32'h0);
    reset_n = 1'b1;
    wq();

    // Pointer 1, two data bytes
    s0 = strobes;
    i2c_start();
    chk("t1_busy_start", 32'(busy), 32'h1);
    send_byte(8'hA4, ack); chk("t1_ack_addr", 32'(ack), 32'h1);
    send_byte(8'h01, ack); chk("t1_ack_ptr",  32'(ack), 32'h1);
    send_byte(8'h5A, ack); chk("t1_ack_d0",   32'(ack), 32'h1);
    send_byte(8'h3C, ack); chk("t1_ack_d1",   32'(ack), 32'h1);
    i2c_stop();
    chk("t1_reg_q",    reg_q,              32'h003C_5AC1);
    chk("t1_strobes",  32'(strobes - s0),  32'd2);
    chk("t1_index0",   32'(idx_log[3'(s0)]),     32'd1);
    chk("t1_index1",   32'(idx_log[3'(s0 + 1)]), 32'd2);
    chk("t1_busy_stop", 32'(busy), 32'h0);

    // Pointer 3, repeated START, read three bytes with wrap 3 -> 0 -> 1
    apply_reset();
    i2c_start();
    send_byte(8'hA4, ack); chk("t2_ack_addr", 32'(ack), 32'h1);
    send_byte(8'h03, ack); chk("t2_ack_ptr",  32'(ack), 32'h1);
    i2c_start();
    send_byte(8'hA5, ack); chk("t2_ack_raddr", 32'(ack), 32'h1);
    recv_byte(1'b0, d, o); chk("t2_rd0", 32'(d), 32'h00); chk("t2_oe_mack0", 32'(o), 32'h0);
    recv_byte(1'b0, d, o); chk("t2_rd1", 32'(d), 32'hC1); chk("t2_oe_mack1", 32'(o), 32'h0);
    recv_byte(1'b1, d, o); chk("t2_rd2", 32'(d), 32'h00);
    i2c_stop();
    chk("t2_busy_stop", 32'(busy), 32'h0);

    // Foreign address is never acknowledged
    apply_reset();
    o0 = oe_cnt;
    i2c_start();
    send_byte(8'hA6, ack); chk("t3_ack_addr", 32'(ack), 32'h0);
    send_byte(8'h55, ack); chk("t3_ack_data", 32'(ack), 32'h0);
    chk("t3_busy_mid", 32'(busy), 32'h1);
    i2c_stop();
    chk("t3_oe_never", 32'(oe_cnt - o0), 32'd0);
    chk("t3_reg_q",    reg_q,             32'h0000_00C1);
    chk("t3_busy_stop", 32'(busy), 32'h0);

    // Out-of-range pointer: acked, write dropped, reads all ones
    s0 = strobes;
    i2c_start();
    send_byte(8'hA4, ack); chk("t4_ack_addr", 32'(ack), 32'h1);
    send_byte(8'h09, ack); chk("t4_ack_ptr",  32'(ack), 32'h1);
    send_byte(8'h77, ack); chk("t4_ack_data", 32'(ack), 32'h1);
    i2c_stop();
    chk("t4_strobes", 32'(strobes - s0), 32'd0);
    chk("t4_reg_q",   reg_q,             32'h0000_00C1);
    i2c_start();
    send_byte(8'hA5, ack); chk("t4_ack_raddr", 32'(ack), 32'h1);
    recv_byte(1'b1, d, o); chk("t4_rd", 32'(d), 32'hFF);
    i2c_stop();

    // STOP after five data bits aborts the byte
    s0 = strobes;
    i2c_start();
    send_byte(8'hA4, ack); chk("t5_ack_addr", 32'(ack), 32'h1);
    send_byte(8'h00, ack); chk("t5_ack_ptr",  32'(ack), 32'h1);
    send_bit(1'b1, l, o); send_bit(1'b0, l, o); send_bit(1'b1, l, o);
    send_bit(1'b1, l, o); send_bit(1'b0, l, o);
    i2c_stop();
    chk("t5_sda_oe",  32'(sda_oe),        32'h0);
    chk("t5_busy",    32'(busy),          32'h0);
    chk("t5_strobes", 32'(strobes - s0),  32'd0);
    chk("t5_reg_q",   reg_q,              32'h0000_00C1);
    send_byte(8'hA4, ack); chk("t5_idle_noack", 32'(ack), 32'h0);
    i2c_stop();

    // Reset while the target holds its address ACK
    i2c_start();
    send_byte(8'hA4, ack); chk("t6_ack_addr", 32'(ack), 32'h1);
    send_byte(8'h02, ack); chk("t6_ack_ptr",  32'(ack), 32'h1);
    send_byte(8'h99, ack); chk("t6_ack_data", 32'(ack), 32'h1);
    i2c_stop();
    chk("t6_reg_q_pre", reg_q, 32'h0099_00C1);
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5 || i == 2, l, o);
    sda_m = 1'b1;
    chk("t6_oe_in_ack", 32'(sda_oe), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("t6_oe_reset",    32'(sda_oe), 32'h0);
    chk("t6_reg_q_reset", reg_q,       32'h0000_00C1);
    send_bit(1'b1, l, o);
    @(negedge clk);
    reset_n = 1'b1;
    send_byte(8'hA4, ack); chk("t6_post_noack", 32'(ack), 32'h0);
    chk("t6_post_busy", 32'(busy), 32'h0);
    i2c_stop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
